// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between the I-cache and D-cache.
// Grants are held until mem_ready; a RELEASE cycle forces a strobe-low gap between transactions.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  conflict_cnt
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_t            state;
    logic              last_grant;
    logic [DATA_W-1:0] rdata_hold;
    logic              req_i, req_d, gnt_i, gnt_d;

    assign req_i = i_mem_read;
    assign req_d = d_mem_read | d_mem_write;
    assign gnt_i = (state == GRANT_I);
    assign gnt_d = (state == GRANT_D);

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            rdata_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i && req_d)
                        state <= (last_grant == GNT_D) ? GRANT_I : GRANT_D;
                    else if (req_i)
                        state <= GRANT_I;
                    else if (req_d)
                        state <= GRANT_D;
                end
                GRANT_I: begin
                    // a dropped request abandons the grant without a ready pulse
                    if (!req_i) begin
                        state <= RELEASE;
                    end else if (mem_ready) begin
                        rdata_hold <= mem_rdata;
                        last_grant <= GNT_I;
                        state      <= RELEASE;
                    end
                end
                GRANT_D: begin
                    if (!req_d) begin
                        state <= RELEASE;
                    end else if (mem_ready) begin
                        if (!d_mem_write)
                            rdata_hold <= mem_rdata;
                        last_grant <= GNT_D;
                        state      <= RELEASE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset)
            conflict_cnt <= '0;
        else if (((gnt_i && req_d) || (gnt_d && req_i)) && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign mem_read  = gnt_i | (gnt_d & ~d_mem_write);
    assign mem_write = gnt_d & d_mem_write;
    assign mem_addr  = gnt_i ? i_mem_addr : (gnt_d ? d_mem_addr : '0);
    assign mem_wdata = gnt_d ? d_mem_wdata : '0;

    assign i_mem_ready = gnt_i & req_i & mem_ready;
    assign d_mem_ready = gnt_d & req_d & mem_ready;
    // bypass in the ready cycle, then the hold register keeps the block stable
    assign i_mem_rdata = i_mem_ready ? mem_rdata : rdata_hold;
    assign d_mem_rdata = d_mem_ready ? mem_rdata : rdata_hold;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit main-memory port between the read-only instruction cache and the read/write data cache.
- Sits between both cache controllers and the memory model.
- Grants one requester per transaction and holds the grant until mem_ready.
- Forwards data and ready back to the granted cache with a bypassed read-data hold register.
- Arbitration is round-robin on simultaneous requests; a one-cycle release gap separates transactions.

Parameters:
ADDR_W, 28, memory block address width (16-byte blocks)
DATA_W, 128, memory block data width
CNT_W, 16, width of the saturating contention counter

Ports:
clk  in  1  clock, rising edge
proc_reset  in  1  asynchronous active-high reset
i_mem_read  in  1  I-cache read request, level, held until i_mem_ready
i_mem_addr  in  ADDR_W  I-cache block address
i_mem_rdata  out  DATA_W  read data to I-cache
i_mem_ready  out  1  transaction-complete pulse to I-cache
d_mem_read  in  1  D-cache read request, level
d_mem_write  in  1  D-cache write request, level
d_mem_addr  in  ADDR_W  D-cache block address
d_mem_wdata  in  DATA_W  D-cache write data
d_mem_rdata  out  DATA_W  read data to D-cache
d_mem_ready  out  1  transaction-complete pulse to D-cache
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory block address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory completion
conflict_cnt  out  CNT_W  cycles in which both ports requested while one waited; saturates at all-ones

Behaviour:
- Reset (asynchronous, any state, mid-transaction included):
  - state=IDLE, last_grant=I.
  - rdata_hold=0, conflict_cnt=0.
  - All mem_* outputs=0; both *_mem_ready=0.
  - An in-flight memory transaction is abandoned; the memory model is reset by the same proc_reset.
- Request definitions: req_i = i_mem_read; req_d = d_mem_read | d_mem_write.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE:
  - No request: stay in IDLE.
  - Only req_i: go to GRANT_I. Only req_d: go to GRANT_D.
  - Both: grant the port not equal to last_grant (first tie after reset goes to D).
  - The decision is registered; mem strobes assert in the first cycle of GRANT_x, never in IDLE. Latency request->mem strobe is 1 cycle.
- GRANT_I:
  - mem_read=1, mem_write=0, mem_addr=i_mem_addr, mem_wdata=0.
  - On mem_ready: i_mem_ready=1 for that cycle, rdata_hold<=mem_rdata, last_grant<=I, go to RELEASE. Otherwise stay.
- GRANT_D:
  - mem_addr=d_mem_addr, mem_wdata=d_mem_wdata.
  - d_mem_write=1: mem_write=1, mem_read=0 (write wins if both are asserted).
  - Otherwise: mem_read=1, mem_write=0.
  - On mem_ready: d_mem_ready=1, rdata_hold<=mem_rdata (reads only), last_grant<=D, go to RELEASE.
- RELEASE:
  - One cycle; all mem strobes=0; go to IDLE.
  - Guarantees a strobe low gap between back-to-back transactions, e.g. D-cache write-back followed by allocate.
- Requests are sampled only in IDLE.
- A request dropped while granted (protocol violation) forces state to RELEASE with no ready pulse.
- Read data:
  - *_mem_rdata = mem_ready & grant-to-that-port ? mem_rdata : rdata_hold.
  - The value is therefore valid in the ready cycle and stays stable until the next read completes, so a cache may sample it in the following cycle.
- The non-granted port sees ready=0 and is never driven to memory.
- conflict_cnt: +1 in each cycle with state in {GRANT_I, GRANT_D} where the other port's request is also high; saturates, no wrap.

Test Plan:
- Reset, then I-only read of addr 0x0000010 with mem_ready after 3 cycles -> mem_read high in cycles 1-4, i_mem_ready pulse in cycle 4, RELEASE in cycle 5. i_mem_rdata equals mem_rdata in cycle 4 and holds in cycle 5.
- I and D read requests in the same cycle after reset -> D granted first, then I after the RELEASE cycle. conflict_cnt = D's transaction length in cycles.
- Second simultaneous request pair -> round-robin grants I first (last_grant=D). Third pair -> D first.
- D write-back (d_mem_write, wdata=0xDEADBEEF_...) immediately followed by a held d_mem_read -> mem_write phase, one-cycle strobe gap, mem_read phase. Pending I waits until after the write (tie goes to I).
- Assert proc_reset in the middle of GRANT_D -> all strobes and ready outputs 0 immediately (asynchronous). IDLE after release; first tie goes to D again.
- Force conflict_cnt near all-ones with continuous contention -> holds at 0xFFFF, does not wrap to 0.
